pll_lock_ctrl: RTL
==================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles PLL held in reset per attempt; legal 1..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 4096: cycles allowed for LOCK after reset release; legal 1..65535.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 64: consecutive synced-LOCK-high cycles required before clock declared good; legal 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: relock attempts after first timeout before FAULT; legal 0..7.
REQ-005 CLK  input  1  free-running reference clock (same source as PLL PACKAGEPIN); all logic on rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 ENABLE  input  1  level; 1 = bring up PLL, 0 = hold PLL off.
REQ-008 LOCK  input  1  PLL lock, asynchronous to CLK.
REQ-009 DELAY_REQ  input  1  request to load new dynamic delay; held high until DELAY_ACK.
REQ-010 DELAY_VAL  input  4  requested delay, sampled in the DELAY_ACK cycle.
REQ-011 PLLRESETB  output  1  PLL reset, active-low (0 = PLL in reset).
REQ-012 BYPASS  output  1  PLL bypass control.
REQ-013 DYNAMICDELAY  output  4  registered delay to PLL.
REQ-014 DELAY_ACK  output  1  one-cycle acceptance pulse.
REQ-015 CLKGOOD  output  1  PLL output qualified for use.
REQ-016 FAULT  output  1  retries exhausted.
REQ-017 LOCKLOST  output  1  sticky: lock dropped while LOCKED; cleared only by RESET or ENABLE=0.

Function
REQ-018 LOCK SHALL pass a 2-flop synchronizer (lock_s); all decisions use lock_s only, 2-cycle latency.
REQ-019 All outputs SHALL be registered; counters 16-bit, retry counter 3-bit, no wrap (compare-and-stop).
REQ-020 States: IDLE, RST_HOLD, WAIT_LOCK, STABLE, LOCKED, FAULT.
REQ-021 IDLE: PLLRESETB=0, BYPASS=1, CLKGOOD=0; retry count cleared; ENABLE=1 -> RST_HOLD, counter=0.
REQ-022 RST_HOLD: PLLRESETB=0, BYPASS=1; after exactly RESET_CYCLES cycles in state -> WAIT_LOCK, counter=0.
REQ-023 WAIT_LOCK: PLLRESETB=1, BYPASS=1; lock_s=1 -> STABLE, counter=0; LOCK_TIMEOUT cycles without lock_s -> RST_HOLD with retry+1 if retry<MAX_RETRIES, else FAULT.
REQ-024 STABLE: lock_s must stay 1 for LOCK_STABLE_CYCLES consecutive cycles -> LOCKED, retry cleared; lock_s=0 -> WAIT_LOCK with timeout counter restarted (retry unchanged).
REQ-025 LOCKED: PLLRESETB=1, BYPASS=0, CLKGOOD=1; lock_s=0 -> RST_HOLD, CLKGOOD=0 next cycle, LOCKLOST set, retry cleared.
REQ-026 DELAY_REQ accepted only in IDLE or LOCKED: DELAY_ACK pulses 1 cycle, DYNAMICDELAY<=DELAY_VAL same edge; in LOCKED additionally -> RST_HOLD (full relock), CLKGOOD=0 next cycle, LOCKLOST not set.
REQ-027 DELAY_REQ in any other state SHALL be held pending, no ACK, until IDLE or LOCKED reached.
REQ-028 FAULT: FAULT=1, PLLRESETB=0, BYPASS=1, CLKGOOD=0; exit only via ENABLE=0 -> IDLE.
REQ-029 ENABLE=0 in any state SHALL force IDLE next cycle, clear FAULT and LOCKLOST.
REQ-030 Priority per cycle: ENABLE=0 > lock_s loss > DELAY_REQ > counter expiry.

Reset
REQ-031 RESET=1 SHALL asynchronously force IDLE, synchronizer=0, counters=0, PLLRESETB=0, BYPASS=1, DYNAMICDELAY=0, DELAY_ACK=0, CLKGOOD=0, FAULT=0, LOCKLOST=0.
REQ-032 RESET mid-sequence SHALL abort immediately; on release, resume from IDLE per ENABLE.

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-033 ENABLE=1, LOCK rises 5 cycles after PLLRESETB rises -> PLLRESETB low 4 cycles, CLKGOOD=1 and BYPASS=0 exactly 2+8 cycles after LOCK rise.
REQ-034 LOCK held 0 -> three RST_HOLD pulses of 4 cycles each, each followed by 20 cycles WAIT_LOCK, then FAULT=1, PLLRESETB=0; ENABLE=0 -> FAULT=0 next cycle.
REQ-035 LOCK glitches low 1 cycle at stable count 5 -> return to WAIT_LOCK, CLKGOOD stays 0, lock later steady -> full 8-cycle requalification.
REQ-036 In LOCKED, LOCK drops -> CLKGOOD=0 within 3 cycles of drop, LOCKLOST=1 sticky, PLLRESETB low 4 cycles, relock.
REQ-037 In LOCKED, DELAY_REQ=1 DELAY_VAL=4'hA -> one DELAY_ACK pulse, DYNAMICDELAY=4'hA, CLKGOOD=0, relock sequence, LOCKLOST=0; DELAY_REQ during WAIT_LOCK -> no ACK until LOCKED.
REQ-038 RESET asserted during STABLE -> all outputs at REQ-031 values without a clock edge.

Source files
------------

// File: rtl/pll_lock_ctrl_if.sv
// Control/status bundle between the PLL lock sequencer and its environment.
// Master side owns enable/lock/delay request. Slave (the controller) owns the PLL controls and status.
interface pll_lock_ctrl_if;
    logic       enable;
    logic       lock;
    logic       delay_req;
    logic [3:0] delay_val;
    logic       pllresetb;
    logic       bypass;
    logic [3:0] dynamicdelay;
    logic       delay_ack;
    logic       clkgood;
    logic       fault;
    logic       locklost;

    modport master (
        output enable, lock, delay_req, delay_val,
        input  pllresetb, bypass, dynamicdelay, delay_ack, clkgood, fault, locklost
    );

    modport slave (
        input  enable, lock, delay_req, delay_val,
        output pllresetb, bypass, dynamicdelay, delay_ack, clkgood, fault, locklost
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset hold, lock wait with retries, stability qualification, relock on loss/delay change.
// Latency: LOCK seen 2 cycles late via synchronizer, all outputs registered; delay requests wait (no ACK) outside IDLE/LOCKED.
module pll_lock_ctrl #(
    parameter int RESET_CYCLES       = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int MAX_RETRIES        = 3
) (
    input  logic            clk,
    input  logic            rst,
    pll_lock_ctrl_if.slave  bus
);

    localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STB_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_HOLD, S_WAIT_LOCK, S_STABLE, S_LOCKED, S_FAULT
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  retry, retry_nxt;
    logic        lock_m, lock_s;
    logic [3:0]  dly_q, dly_nxt;
    logic        ack_q, ack_nxt;
    logic        lost_q, lost_nxt;
    logic        rstb_q, byp_q, good_q, fault_q;
    logic        take;

    // ACK is a single pulse even if the requester is slow to drop its request
    assign take = bus.delay_req && !ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.lock;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        ack_nxt   = 1'b0;
        dly_nxt   = dly_q;
        lost_nxt  = lost_q;
        if (!bus.enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            retry_nxt = '0;
            lost_nxt  = 1'b0;
            if (state == S_IDLE && take) begin
                ack_nxt = 1'b1;
                dly_nxt = bus.delay_val;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_RST_HOLD;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                    if (take) begin
                        ack_nxt = 1'b1;
                        dly_nxt = bus.delay_val;
                    end
                end
                S_RST_HOLD: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TO_LAST) begin
                        cnt_nxt = '0;
                        if (retry < RETRY_MAX) begin
                            state_nxt = S_RST_HOLD;
                            retry_nxt = retry + 3'd1;
                        end else begin
                            state_nxt = S_FAULT;
                        end
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = S_LOCKED;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                    end
                end
                S_LOCKED: begin
                    if (!lock_s) begin
                        state_nxt = S_RST_HOLD;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                        lost_nxt  = 1'b1;
                    end else if (take) begin
                        // new delay invalidates the current lock: full relock
                        ack_nxt   = 1'b1;
                        dly_nxt   = bus.delay_val;
                        state_nxt = S_RST_HOLD;
                        cnt_nxt   = '0;
                        retry_nxt = '0;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            retry   <= '0;
            dly_q   <= '0;
            ack_q   <= 1'b0;
            lost_q  <= 1'b0;
            rstb_q  <= 1'b0;
            byp_q   <= 1'b1;
            good_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            retry   <= retry_nxt;
            dly_q   <= dly_nxt;
            ack_q   <= ack_nxt;
            lost_q  <= lost_nxt;
            rstb_q  <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) ||
                       (state_nxt == S_LOCKED);
            byp_q   <= (state_nxt != S_LOCKED);
            good_q  <= (state_nxt == S_LOCKED);
            fault_q <= (state_nxt == S_FAULT);
        end
    end

    assign bus.pllresetb    = rstb_q;
    assign bus.bypass       = byp_q;
    assign bus.dynamicdelay = dly_q;
    assign bus.delay_ack    = ack_q;
    assign bus.clkgood      = good_q;
    assign bus.fault        = fault_q;
    assign bus.locklost     = lost_q;

endmodule
